cordic_arbiter: RTL and testbench



---
 rtl/cordic_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/cordic_arbiter.sv | 155 +++++++++++++++
 tb/tb_cordic_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC arbiter: Q16.16 format, opt codes and
// the arbiter FSM state encoding.
package cordic_pkg;

    localparam int Q_WIDTH = 32;
    localparam int Q_FRAC  = 16;

    localparam logic [1:0] OPT_COS  = 2'b00;
    localparam logic [1:0] OPT_SIN  = 2'b01;
    localparam logic [1:0] OPT_BOTH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first asserted request at or after last+1 (mod N)
// wins. Purely combinational; the caller owns the last-grant register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [IW-1:0] idx;
    logic          found;

    // Scan N positions starting just past the previous winner.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one iterative cordic core among N_REQ requesters with round-robin
// arbitration and a one-hot valid/ready response channel.
// Optional feature: define CORDIC_ARB_TIMEOUT_EN to abort an operation whose
// core never signals done within TIMEOUT cycles (response flagged rsp_err).
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [Q_WIDTH*N_REQ-1:0] req_angle,
    input  logic [2*N_REQ-1:0]       req_opt,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [Q_WIDTH-1:0]       rsp_sin,
    output logic [Q_WIDTH-1:0]       rsp_cos,
    output logic                     rsp_err,
    output logic [Q_WIDTH-1:0]       cordic_angle,
    output logic [1:0]               cordic_opt,
    output logic                     cordic_enable,
    input  logic [Q_WIDTH-1:0]       cordic_sin,
    input  logic [Q_WIDTH-1:0]       cordic_cos,
    input  logic                     cordic_done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cordic_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [Q_WIDTH-1:0] angle_q, angle_d;
    logic [1:0]         opt_q, opt_d;
    logic [Q_WIDTH-1:0] sin_q, sin_d;
    logic [Q_WIDTH-1:0] cos_q, cos_d;

    logic [N_REQ-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req_i     (req_valid),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    // Next-state and datapath capture; everything holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        angle_d = angle_q;
        opt_d   = opt_q;
        sin_d   = sin_q;
        cos_d   = cos_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    last_d  = gnt_idx;
                    angle_d = req_angle[Q_WIDTH*gnt_idx +: Q_WIDTH];
                    opt_d   = req_opt[2*gnt_idx +: 2];
                    state_d = ST_BUSY;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (cordic_done) begin
                    sin_d   = cordic_sin;
                    cos_d   = cordic_cos;
                    state_d = ST_RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Core never answered: return a zeroed, error-flagged result.
                    sin_d   = '0;
                    cos_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready[last_q]) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A core may hold done high after enable drops; wait it out.
                if (!cordic_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and operand/result registers; last grant resets so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(N_REQ - 1);
            angle_q <= '0;
            opt_q   <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            angle_q <= angle_d;
            opt_q   <= opt_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    // req_ready is gated by reset so no accept strobe shows while reset is held.
    assign req_ready     = (state_q == ST_IDLE && reset) ? gnt : '0;
    assign cordic_enable = (state_q == ST_BUSY);
    assign rsp_valid     = (state_q == ST_RESP) ? (N_REQ'(1) << last_q) : '0;
    assign rsp_sin       = sin_q;
    assign rsp_cos       = cos_q;
    assign cordic_angle  = angle_q;
    assign cordic_opt    = opt_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    assign rsp_err       = err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_cordic_arbiter;
    import cordic_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0] req_angle;
    logic [2*N-1:0]  req_opt;
    logic [31:0]     rsp_sin, rsp_cos, cordic_angle, csin, ccos;
    logic            rsp_err, cordic_enable, done;
    logic [1:0]      cordic_opt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural core knobs.
    int lat = 3;
    int sticky_n = 0;
    bit never = 1'b0;
    int ecnt, stick;

    always #5 clk = ~clk;

    cordic_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_opt(req_opt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sin(rsp_sin), .rsp_cos(rsp_cos), .rsp_err(rsp_err),
        .cordic_angle(cordic_angle), .cordic_opt(cordic_opt),
        .cordic_enable(cordic_enable),
        .cordic_sin(csin), .cordic_cos(ccos), .cordic_done(done)
    );

    function automatic logic [31:0] f_sin(input logic [31:0] a);
        real r;
        logic [31:0] v;
        r = $itor($signed(a)) / 65536.0;
        v = $rtoi($sin(r) * 65536.0);
        return v;
    endfunction

    function automatic logic [31:0] f_cos(input logic [31:0] a);
        real r;
        logic [31:0] v;
        r = $itor($signed(a)) / 65536.0;
        v = $rtoi($cos(r) * 65536.0);
        return v;
    endfunction

    // Core model: done after lat enabled cycles, optionally sticky for a while.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ecnt <= 0; stick <= 0; done <= 1'b0; csin <= '0; ccos <= '0;
        end else if (cordic_enable) begin
            ecnt  <= ecnt + 1;
            stick <= sticky_n;
            csin  <= f_sin(cordic_angle);
            ccos  <= f_cos(cordic_angle);
            if (!never && ecnt + 1 >= lat) done <= 1'b1;
        end else begin
            ecnt <= 0;
            if (done) begin
                if (stick > 0) stick <= stick - 1;
                else done <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input int exp, input int tol);
        n_cmp++;
        if (act < exp - tol || act > exp + tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one;
        one = 1;
        return one << i;
    endfunction

    function automatic logic [31:0] rand_ang();
        int a;
        a = int'($urandom_range(0, 205887)) - 102943;
        return a;
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0; req_valid = '0; rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Full transaction: expects grant exp_g (called at a negedge with inputs set).
    task automatic serve(input int exp_g, input string nm);
        int n;
        logic [31:0] a;
        #1;
        n = 0;
        while (req_ready == '0 && n < 60) begin @(negedge clk); #1; n++; end
        chk({nm, "_grant"}, req_ready, oh(exp_g));
        a = req_angle[exp_g*32 +: 32];
        @(negedge clk);
        req_valid[exp_g] = 1'b0;
        #1;
        n = 0;
        while (rsp_valid == '0 && n < 60) begin @(negedge clk); #1; n++; end
        chk({nm, "_rsp_valid"}, rsp_valid, oh(exp_g));
        chk({nm, "_sin"}, rsp_sin, f_sin(a));
        chk({nm, "_cos"}, rsp_cos, f_cos(a));
        rsp_ready = oh(exp_g);
        @(negedge clk);
        rsp_ready = '0;
    endtask

    typedef struct {
        logic [N-1:0] vmask;
        logic [31:0]  angle;
        logic [N-1:0] exp_gnt;
        int           exp_sin;
        int           exp_cos;
        int           hold;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        int n;
        logic [31:0] s0, c0;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (v.vmask[i]) begin
                req_angle[i*32 +: 32] = v.angle;
                req_opt[i*2 +: 2] = OPT_BOTH;
            end
        req_valid = v.vmask; rsp_ready = '0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 40) begin @(negedge clk); #1; n++; end
        chk($sformatf("vec%0d_grant", id), req_ready, v.exp_gnt);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk($sformatf("vec%0d_en_next", id), cordic_enable, 1);
        chk($sformatf("vec%0d_opt", id), cordic_opt, OPT_BOTH);
        n = 0;
        while (rsp_valid == '0 && n < 40) begin @(negedge clk); #1; n++; end
        chk($sformatf("vec%0d_rsp_valid", id), rsp_valid, v.exp_gnt);
        chk_near($sformatf("vec%0d_sin", id), int'($signed(rsp_sin)), v.exp_sin, 4);
        chk_near($sformatf("vec%0d_cos", id), int'($signed(rsp_cos)), v.exp_cos, 4);
        chk($sformatf("vec%0d_err", id), rsp_err, 0);
        chk($sformatf("vec%0d_en_off", id), cordic_enable, 0);
        s0 = rsp_sin; c0 = rsp_cos;
        // Non-granted readies and fresh requests must both be ignored while held.
        rsp_ready = ~v.exp_gnt; req_valid = '1;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk); #1;
            chk($sformatf("vec%0d_hold_valid", id), rsp_valid, v.exp_gnt);
            chk($sformatf("vec%0d_hold_data", id), {rsp_sin, rsp_cos}, {s0, c0});
            chk($sformatf("vec%0d_hold_rdy", id), req_ready, 0);
            chk($sformatf("vec%0d_hold_en", id), cordic_enable, 0);
        end
        @(negedge clk);
        req_valid = '0; rsp_ready = v.exp_gnt;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        chk($sformatf("vec%0d_rsp_drop", id), rsp_valid, 0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_rsp_valid"}, rsp_valid, 0);
        chk({nm, "_data"}, {rsp_sin, rsp_cos, rsp_err}, 0);
        chk({nm, "_core"}, {cordic_angle, cordic_opt, cordic_enable}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   n, ph, g_m, last_m, pg;
        bit   prevd;
        logic [31:0]  ang_m;
        logic [N-1:0] acc_prev, exp_rr;

        // Sequence from reset (requester 3 counts as last winner).
        vecs[0] = '{4'b0001, 32'd0,       4'b0001,      0,  65536, 0};
        vecs[1] = '{4'b0110, 32'd51472,   4'b0010,  46341,  46341, 10};
        vecs[2] = '{4'b0110, 32'd102944,  4'b0100,  65536,      0, 0};
        vecs[3] = '{4'b1001, -32'sd51472, 4'b1000, -46341,  46341, 2};
        vecs[4] = '{4'b1001, 32'd0,       4'b0001,      0,  65536, 0};
        vecs[5] = '{4'b1111, 32'd51472,   4'b0010,  46341,  46341, 1};
        vecs[6] = '{4'b1000, 32'd0,       4'b1000,      0,  65536, 0};
        vecs[7] = '{4'b0101, 32'd102944,  4'b0001,  65536,      0, 0};
        vecs[8] = '{4'b0101, 32'd0,       4'b0100,      0,  65536, 0};

        reset = 1'b0; req_valid = '1; rsp_ready = '0;
        req_angle = '0; req_opt = '0;
        for (int i = 0; i < N; i++) req_angle[i*32 +: 32] = 32'd51472;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk_all_zero("post_reset_idle");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Rotation with three requesters held high; 1 is re-raised after its turn.
        pulse_reset();
        req_valid = 4'b0111;
        for (int i = 0; i < N; i++) req_angle[i*32 +: 32] = rand_ang();
        serve(0, "rot0");
        serve(1, "rot1");
        req_valid[1] = 1'b1;
        serve(2, "rot2");
        serve(1, "rot1b");

        // Reset three cycles into BUSY discards the operation.
        @(negedge clk);
        lat = 8;
        req_valid = 4'b0010;
        req_angle[32 +: 32] = 32'd51472;
        #1;
        chk("rstbusy_grant", req_ready, 4'b0010);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = '1;
        #1;
        chk_all_zero("rstbusy");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk_all_zero("rstbusy_hold");
        end
        @(negedge clk);
        reset = 1'b1; req_valid = 4'b0001; lat = 3;
        req_angle[0 +: 32] = 32'd51472;
        serve(0, "after_rst");

        // Sticky done: next accept only after done falls.
        @(negedge clk);
        sticky_n = 5;
        req_valid = 4'b0001;
        serve(0, "sticky_first");
        req_valid = 4'b0010;
        #1;
        n = 0; prevd = 1'b1;
        while (req_ready == '0 && n < 60) begin
            prevd = done;
            @(negedge clk); #1; n++;
        end
        chk("sticky_prev_done", prevd, 0);
        chk("sticky_waited", n >= 4, 1);
        serve(1, "sticky_next");
        sticky_n = 0;

`ifdef CORDIC_ARB_TIMEOUT_EN
        @(negedge clk);
        @(negedge clk);
        never = 1'b1;
        req_valid = 4'b0100;
        #1;
        n = 0;
        while (req_ready == '0 && n < 60) begin @(negedge clk); #1; n++; end
        chk("to_grant", req_ready, 4'b0100);
        @(negedge clk); req_valid = '0; #1;
        n = 1;
        while (rsp_valid == '0 && n < 200) begin @(negedge clk); #1; n++; end
        chk("to_latency", n, TO + 1);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_sin, rsp_cos}, {4'b0100, 1'b1, 64'd0});
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0; never = 1'b0;
`endif

        // Randomized run against a transaction-phase model.
        pulse_reset();
        ph = 0; last_m = N - 1; g_m = 0; ang_m = '0; acc_prev = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (acc_prev[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i]) begin
                    req_angle[i*32 +: 32] = rand_ang();
                    req_opt[i*2 +: 2] = OPT_BOTH;
                    if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
                end else if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = N'($urandom);
            #1;
            case (ph)
                0: begin
                    pg = pick(req_valid, last_m);
                    exp_rr = (pg >= 0) ? oh(pg) : '0;
                    chk("rnd_idle_rdy", req_ready, exp_rr);
                    chk("rnd_idle_out", {cordic_enable, rsp_valid}, 0);
                    if (pg >= 0) begin
                        g_m = pg; last_m = pg;
                        ang_m = req_angle[pg*32 +: 32];
                        ph = 1;
                    end else if (!done) begin
                        lat = $urandom_range(1, 5);
                        sticky_n = $urandom_range(0, 3);
                    end
                end
                1: begin
                    chk("rnd_busy", {req_ready, rsp_valid, cordic_enable}, 9'b1);
                    chk("rnd_busy_angle", cordic_angle, ang_m);
                    if (done) ph = 2;
                end
                2: begin
                    chk("rnd_resp_valid", {req_ready, rsp_valid, cordic_enable}, {4'b0, oh(g_m), 1'b0});
                    chk("rnd_resp_data", {rsp_sin, rsp_cos, rsp_err}, {f_sin(ang_m), f_cos(ang_m), 1'b0});
                    if (rsp_ready[g_m]) ph = 3;
                end
                default: begin
                    chk("rnd_drain", {req_ready, rsp_valid, cordic_enable}, 0);
                    if (!done) ph = 0;
                end
            endcase
            acc_prev = req_ready;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
